// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock keypad entry path: key codes,
// 24-hour limits, entry state encoding and the HH:MM legality check.
package alarm_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_NONE      = 4'd10;

    localparam logic [3:0] HR_TENS_MAX       = 4'd2;
    localparam logic [3:0] HR_UNITS_MAX_AT_2 = 4'd3;
    localparam logic [3:0] MIN_TENS_MAX      = 4'd5;

    localparam logic [2:0] ENTRY_DIGITS = 3'd4;

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } entry_state_t;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } digits_t;

    // Hours 00..23 and minutes 00..59, judged digit by digit.
    function automatic logic is_legal_time(input digits_t d);
        logic hr_ok;
        hr_ok = (d.ms_hr < HR_TENS_MAX) ? (d.ls_hr <= KEY_DIGIT_MAX) :
                (d.ms_hr == HR_TENS_MAX) ? (d.ls_hr <= HR_UNITS_MAX_AT_2) : 1'b0;
        return hr_ok && (d.ms_min <= MIN_TENS_MAX) && (d.ls_min <= KEY_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/key_timeout_counter.sv
// 8-bit inactivity down-counter; expire fires on the tick that takes it
// from 1 to 0, unless a load arrives in the same cycle.
module key_timeout_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       tick,
    input  logic [7:0] timeout_s,
    output logic       expire
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= timeout_s;
        end else if (tick && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expire = tick && !load && (count == 8'd1);

endmodule

// File: rtl/alarm_key_entry.sv
// Keypad digit entry for the alarm display: shifts digits in right-to-left,
// tracks progress and legality, and abandons an idle entry after TIMEOUT_S ticks.
module alarm_key_entry
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] key_ms_hr,
    output logic [3:0] key_ls_hr,
    output logic [3:0] key_ms_min,
    output logic [3:0] key_ls_min,
    output logic [2:0] digit_count,
    output logic       entry_active,
    output logic       entry_full,
    output logic       time_valid,
    output logic       timeout
);

    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_S);

    entry_state_t state, state_next;
    digits_t      digits, digits_next;
    logic [2:0]   count, count_next;
    logic         valid_q, valid_next;
    logic         timeout_q, timeout_next;
    logic         digit_accept;
    logic         expire;

    assign digit_accept = key_valid && (key <= KEY_DIGIT_MAX);

    key_timeout_counter u_timer (
        .clock     (clock),
        .reset     (reset),
        .load      (digit_accept),
        .tick      (one_second && state == ENTRY),
        .timeout_s (TIMEOUT_V),
        .expire    (expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            digits    <= '0;
            count     <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            digits    <= digits_next;
            count     <= count_next;
            valid_q   <= valid_next;
            timeout_q <= timeout_next;
        end
    end

    // NOTE: every signal gets its default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        digits_next  = digits;
        count_next   = count;
        timeout_next = 1'b0;

        case (state)
            IDLE: begin
                if (digit_accept) state_next = ENTRY;
            end
            ENTRY: begin
                if (!digit_accept && expire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A digit always beats an expiring tick in the same cycle.
        if (digit_accept) begin
            digits_next = '{ms_hr: digits.ls_hr, ls_hr: digits.ms_min,
                            ms_min: digits.ls_min, ls_min: key};
            if (count != ENTRY_DIGITS) count_next = count + 3'd1;
        end else if (expire) begin
            digits_next  = '0;
            count_next   = 3'd0;
            timeout_next = 1'b1;
        end

        valid_next = (count_next == ENTRY_DIGITS) && is_legal_time(digits_next);
    end

    assign key_ms_hr    = digits.ms_hr;
    assign key_ls_hr    = digits.ls_hr;
    assign key_ms_min   = digits.ms_min;
    assign key_ls_min   = digits.ls_min;
    assign digit_count  = count;
    assign entry_active = (state == ENTRY);
    assign entry_full   = (count == ENTRY_DIGITS);
    assign time_valid   = valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_alarm_key_entry.sv
// Scoreboard bench for alarm_key_entry: a queue-based entry model predicts
// every cycle's outputs; a monitor compares them after each rising edge.
module tb_alarm_key_entry;

    localparam int T = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
    logic [2:0] digit_count;
    logic       entry_active, entry_full, time_valid, timeout;

    alarm_key_entry #(.TIMEOUT_S(T)) dut (
        .clock        (clock),
        .reset        (reset),
        .one_second   (one_second),
        .key_valid    (key_valid),
        .key          (key),
        .key_ms_hr    (key_ms_hr),
        .key_ls_hr    (key_ls_hr),
        .key_ms_min   (key_ms_min),
        .key_ls_min   (key_ls_min),
        .digit_count  (digit_count),
        .entry_active (entry_active),
        .entry_full   (entry_full),
        .time_valid   (time_valid),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] d0, d1, d2, d3;
        logic [2:0] cnt;
        logic       act, full, tv, to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the list of digits typed so far (newest last),
    // whether an entry is open, and the seconds left before it is dropped.
    int   entered[$];
    bit   open_entry = 1'b0;
    int   secs_left = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input bit kv, input int k, input bit tk, input bit rst);
        exp_t e;
        int   d[4];
        int   n;
        bit   expired;
        expired = 1'b0;
        if (rst) begin
            entered.delete();
            open_entry = 1'b0;
            secs_left  = 0;
        end else if (kv && k < 10) begin
            entered.push_back(k);
            if (entered.size() > 4) void'(entered.pop_front());
            open_entry = 1'b1;
            secs_left  = T;
        end else if (open_entry && tk) begin
            secs_left--;
            if (secs_left == 0) begin
                entered.delete();
                open_entry = 1'b0;
                expired    = 1'b1;
            end
        end
        n = entered.size();
        for (int i = 0; i < 4; i++) d[i] = (n - 4 + i >= 0) ? entered[n - 4 + i] : 0;
        e.d0   = 4'(d[0]);
        e.d1   = 4'(d[1]);
        e.d2   = 4'(d[2]);
        e.d3   = 4'(d[3]);
        e.cnt  = 3'(n);
        e.act  = open_entry;
        e.full = (n == 4);
        e.tv   = (n == 4) && (d[0] * 10 + d[1] < 24) && (d[2] * 10 + d[3] < 60);
        e.to   = expired;
        return e;
    endfunction

    task automatic step(input bit kv, input logic [3:0] k, input bit tk, input bit rst);
        @(negedge clock);
        key_valid  = kv;
        key        = k;
        one_second = tk;
        reset      = rst;
        sb.push_back(predict(kv, int'(k), tk, rst));
    endtask

    task automatic digit(input logic [3:0] k);
        step(1'b1, k, 1'b0, 1'b0);
    endtask

    task automatic tick();
        step(1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ms_hr",        8'(key_ms_hr),    8'(e.d0));
            check("ls_hr",        8'(key_ls_hr),    8'(e.d1));
            check("ms_min",       8'(key_ms_min),   8'(e.d2));
            check("ls_min",       8'(key_ls_min),   8'(e.d3));
            check("digit_count",  8'(digit_count),  8'(e.cnt));
            check("entry_active", 8'(entry_active), 8'(e.act));
            check("entry_full",   8'(entry_full),   8'(e.full));
            check("time_valid",   8'(time_valid),   8'(e.tv));
            check("timeout",      8'(timeout),      8'(e.to));
        end
    end

    initial begin
        do_reset();
        idle(1);

        // 12:34 is legal; 25:00 is not; a fifth digit drops the oldest.
        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
        digit(4'd2); digit(4'd5); digit(4'd0); digit(4'd0);
        digit(4'd9);
        do_reset();

        // Non-digit ignored, then abandoned after T ticks; idle ticks do nothing.
        digit(4'd1); step(1'b1, 4'd11, 1'b0, 1'b0);
        idle(2);
        tick(); idle(1); tick(); tick();
        idle(1); tick(); tick();

        // Digit on the would-be expiring tick wins and reloads the counter.
        digit(4'd7);
        for (int i = 0; i < T - 1; i++) tick();
        step(1'b1, 4'd8, 1'b1, 1'b0);
        for (int i = 0; i < T; i++) tick();
        idle(1);

        // Reset mid-entry drops the key presented alongside it.
        digit(4'd1); digit(4'd9);
        step(1'b1, 4'd5, 1'b0, 1'b1);
        idle(1);

        // Boundary hours: 23:59 legal, 24:00 not; also 19:59 and 20:60.
        digit(4'd2); digit(4'd3); digit(4'd5); digit(4'd9);
        digit(4'd2); digit(4'd4); digit(4'd0); digit(4'd0);
        digit(4'd1); digit(4'd9); digit(4'd5); digit(4'd9);
        digit(4'd2); digit(4'd0); digit(4'd6); digit(4'd0);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end

        idle(2);
        @(posedge clock);
        #2;
        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
